// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage RISC-V core.
// Decodes the ID-stage source-register usage and detects load-use hazards
// against EX. It arbitrates between a data-cache freeze, a load-use bubble
// and a taken-branch flush. It also keeps saturating event counters for
// performance analysis.
module hazard_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      id_inst_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_stall_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             freeze_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2
  } state_t;

  // Opcode classes shared with the immediate generator
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;

  state_t state_q;
  state_t state_d;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;

  // Which condition won arbitration this cycle; drives the counters
  logic       ev_freeze;
  logic       ev_bubble;
  logic       ev_flush;

  // Instruction bits that play no part in source decode
  logic       unused_inst;

  assign opcode      = id_inst_i[6:0];
  assign rs1         = id_inst_i[19:15];
  assign rs2         = id_inst_i[24:20];
  assign unused_inst = ^{id_inst_i[31:25], id_inst_i[14:7]};

  // Saturating increment: holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    if (&v) begin
      return v;
    end
    return v + one;
  endfunction

  // Source-register usage by opcode class
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_RTYPE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IALU:  begin use_rs1 = 1'b1; end
      OP_LOAD:  begin use_rs1 = 1'b1; end
      OP_STORE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BRNCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default:  begin use_rs1 = 1'b0; use_rs2 = 1'b0; end
    endcase
  end

  // Load-use hazard: x0 is never a real dependency
  assign hazard = ex_memread_i && (ex_rd_i != 5'd0) &&
                  ((use_rs1 && (rs1 == ex_rd_i)) ||
                   (use_rs2 && (rs2 == ex_rd_i)));

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (!start_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     if (mem_stall_i) state_d = FREEZE;
        FREEZE:  if (!mem_stall_i) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Prioritised Mealy outputs; FREEZE and RUN share the same decision
  // ladder, so the release cycle acts on hazard/branch with no dead cycle.
  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    freeze_o      = 1'b0;
    ev_freeze     = 1'b0;
    ev_bubble     = 1'b0;
    ev_flush      = 1'b0;
    if ((state_q == IDLE) || !start_i) begin
      freeze_o = 1'b1;
    end else if (mem_stall_i) begin
      freeze_o  = 1'b1;
      ev_freeze = 1'b1;
    end else if (hazard) begin
      // A taken beq waits one cycle for the forwarded load data
      idex_bubble_o = 1'b1;
      ev_bubble     = 1'b1;
    end else if (branch_taken_i) begin
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      ifid_flush_o = 1'b1;
      ev_flush     = 1'b1;
    end else begin
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
    end
  end

  // Event counters; only reset clears them, start_i does not
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
      freeze_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (ev_bubble) bubble_cnt_o <= sat_inc(bubble_cnt_o);
      if (ev_freeze) freeze_cnt_o <= sat_inc(freeze_cnt_o);
      if (ev_flush)  flush_cnt_o  <= sat_inc(flush_cnt_o);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a 32-bit-counter and a 4-bit-counter instance
// share one stimulus stream; a reference model pushes expectations into a
// scoreboard and a monitor pops and compares them on every falling edge.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] id_inst_i = 32'h0000_0013;
  logic        ex_memread_i = 1'b0;
  logic [4:0]  ex_rd_i = 5'd0;
  logic        branch_taken_i = 1'b0;
  logic        mem_stall_i = 1'b0;

  logic        a_pc, a_ifw, a_fl, a_bub, a_frz;
  logic [1:0]  a_st;
  logic [31:0] a_bc, a_fc, a_flc;
  logic        b_pc, b_ifw, b_fl, b_bub, b_frz;
  logic [1:0]  b_st;
  logic [3:0]  b_bc, b_fc, b_flc;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.CNT_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .id_inst_i(id_inst_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .branch_taken_i(branch_taken_i), .mem_stall_i(mem_stall_i),
    .pc_write_o(a_pc), .ifid_write_o(a_ifw), .ifid_flush_o(a_fl),
    .idex_bubble_o(a_bub), .freeze_o(a_frz), .state_o(a_st),
    .bubble_cnt_o(a_bc), .freeze_cnt_o(a_fc), .flush_cnt_o(a_flc)
  );

  hazard_stall_ctrl #(.CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .id_inst_i(id_inst_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .branch_taken_i(branch_taken_i), .mem_stall_i(mem_stall_i),
    .pc_write_o(b_pc), .ifid_write_o(b_ifw), .ifid_flush_o(b_fl),
    .idex_bubble_o(b_bub), .freeze_o(b_frz), .state_o(b_st),
    .bubble_cnt_o(b_bc), .freeze_cnt_o(b_fc), .flush_cnt_o(b_flc)
  );

  typedef struct {
    bit     pc, ifw, fl, bub, frz;
    int     st;
    longint bc, fc, flc, bc4, fc4, flc4;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_pass = 0;

  // Reference model: mode 0 idle, 1 running, 2 frozen; cls = winning priority
  int     m_st = 0;
  int     m_cls = 0;
  longint m_bc = 0, m_fc = 0, m_flc = 0, m_bc4 = 0, m_fc4 = 0, m_flc4 = 0;

  function automatic longint sat(input longint v, input int w);
    longint top;
    top = (longint'(1) << w) - 1;
    return (v >= top) ? v : v + 1;
  endfunction

  function automatic bit model_hazard();
    bit u1, u2;
    int op;
    op = int'(id_inst_i[6:0]);
    u1 = (op == 'h33) || (op == 'h13) || (op == 'h03) || (op == 'h23) || (op == 'h63);
    u2 = (op == 'h33) || (op == 'h23) || (op == 'h63);
    if (!ex_memread_i || ex_rd_i == 0) return 1'b0;
    return (u1 && id_inst_i[19:15] == ex_rd_i) || (u2 && id_inst_i[24:20] == ex_rd_i);
  endfunction

  task automatic model_edge();
    if (m_cls == 1) begin m_fc = sat(m_fc, 32); m_fc4 = sat(m_fc4, 4); end
    if (m_cls == 2) begin m_bc = sat(m_bc, 32); m_bc4 = sat(m_bc4, 4); end
    if (m_cls == 3) begin m_flc = sat(m_flc, 32); m_flc4 = sat(m_flc4, 4); end
    if (!start_i) m_st = 0;
    else if (m_st == 0) m_st = 1;
    else m_st = mem_stall_i ? 2 : 1;
  endtask

  task automatic push_exp();
    exp_t e;
    if (m_st == 0 || !start_i) m_cls = 0;
    else if (mem_stall_i) m_cls = 1;
    else if (model_hazard()) m_cls = 2;
    else if (branch_taken_i) m_cls = 3;
    else m_cls = 4;
    e.frz = (m_cls <= 1);
    e.pc  = (m_cls >= 3);
    e.ifw = (m_cls >= 3);
    e.fl  = (m_cls == 3);
    e.bub = (m_cls == 2);
    e.st  = m_st;
    e.bc = m_bc; e.fc = m_fc; e.flc = m_flc;
    e.bc4 = m_bc4; e.fc4 = m_fc4; e.flc4 = m_flc4;
    sb.push_back(e);
  endtask

  // Reset asserted mid-cycle (asynchronously) and released before the next edge
  task automatic do_reset();
    @(posedge clk); #1;
    if (!rst_i) model_edge();
    rst_i = 1'b1;
    m_st = 0;
    m_bc = 0; m_fc = 0; m_flc = 0; m_bc4 = 0; m_fc4 = 0; m_flc4 = 0;
    push_exp();
    #6 rst_i = 1'b0;
  endtask

  task automatic cyc(input bit st, input bit ms, input bit bt, input bit mr,
                     input logic [4:0] rd, input logic [31:0] inst);
    @(posedge clk); #1;
    if (!rst_i) model_edge();
    start_i = st; mem_stall_i = ms; branch_taken_i = bt;
    ex_memread_i = mr; ex_rd_i = rd; id_inst_i = inst;
    push_exp();
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares every presented cycle against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_write", a_pc, e.pc);
        chk("ifid_write", a_ifw, e.ifw);
        chk("ifid_flush", a_fl, e.fl);
        chk("idex_bubble", a_bub, e.bub);
        chk("freeze", a_frz, e.frz);
        chk("state", a_st, e.st);
        chk("bubble_cnt", a_bc, e.bc);
        chk("freeze_cnt", a_fc, e.fc);
        chk("flush_cnt", a_flc, e.flc);
        chk("w4_outputs", {b_pc, b_ifw, b_fl, b_bub, b_frz, b_st},
            {e.pc, e.ifw, e.fl, e.bub, e.frz, 2'(e.st)});
        chk("w4_bubble_cnt", b_bc, e.bc4);
        chk("w4_freeze_cnt", b_fc, e.fc4);
        chk("w4_flush_cnt", b_flc, e.flc4);
      end
    end
  end

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADD  = 32'h0072_8333;
  localparam logic [31:0] ADDI = 32'h0051_0093;
  localparam logic [31:0] SW   = 32'h0051_2023;
  localparam logic [31:0] ADX0 = 32'h0010_0093;

  initial begin
    logic [6:0] ops [8];
    logic [31:0] inst;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h37, 7'h00};

    do_reset();
    cyc(1, 0, 0, 0, 0, NOP);            // IDLE -> RUN
    cyc(1, 0, 0, 1, 5, ADD);            // load-use bubble
    cyc(1, 0, 0, 0, 0, NOP);            // bubble_cnt = 1
    cyc(1, 0, 0, 1, 5, ADDI);           // rs2 field unused
    cyc(1, 0, 0, 1, 5, SW);             // sw rs2 hazard
    cyc(1, 0, 0, 1, 0, ADX0);           // x0 never hazards
    repeat (3) cyc(1, 1, 1, 1, 5, ADD); // freeze overrides all
    cyc(1, 0, 1, 1, 5, ADD);            // release: bubble beats branch
    cyc(1, 0, 1, 0, 0, ADD);            // branch now flushes
    cyc(1, 0, 0, 0, 0, NOP);
    cyc(1, 0, 1, 0, 0, NOP);
    cyc(1, 0, 1, 0, 0, NOP);
    cyc(1, 0, 0, 0, 0, NOP);
    cyc(1, 1, 0, 0, 0, NOP);
    cyc(1, 1, 0, 0, 0, NOP);            // in FREEZE with counters nonzero
    do_reset();
    cyc(1, 0, 0, 0, 0, NOP);
    cyc(1, 0, 0, 0, 0, NOP);            // RUN again
    cyc(0, 0, 1, 1, 5, ADD);            // start low: idle outputs
    cyc(1, 0, 0, 0, 0, NOP);
    repeat (20) cyc(1, 0, 0, 1, 5, ADD); // 4-bit counter saturates
    cyc(1, 0, 0, 0, 0, NOP);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        inst = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                3'($urandom), 5'($urandom), ops[$urandom_range(0, 7)]};
        cyc($urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 1'($urandom), 5'($urandom_range(0, 7)), inst);
      end
    end

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Decodes the ID-stage instruction's source-register usage by opcode, using the same opcode classes as the immediate generator.
- Detects load-use hazards against EX and arbitrates between three conditions: data-cache freeze, load-use bubble and taken-branch flush.
- Drives PC / IF/ID write enables, the ID/EX bubble and the pipeline freeze, and keeps saturating event counters for performance analysis.

Parameters:
- CNT_W, 32, width of each event counter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  core enable; 0 holds the pipeline idle.
- id_inst_i  in  32  instruction in the IF/ID register.
- ex_memread_i  in  1  instruction in EX is a load.
- ex_rd_i  in  5  destination register of the instruction in EX.
- branch_taken_i  in  1  beq in ID resolved taken.
- mem_stall_i  in  1  data cache busy; the whole pipeline must hold.
- pc_write_o  out  1  PC register load enable.
- ifid_write_o  out  1  IF/ID register load enable.
- ifid_flush_o  out  1  IF/ID loads a NOP (squashes the fetched instruction).
- idex_bubble_o  out  1  ID/EX control fields forced to zero.
- freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
- state_o  out  2  FSM state: 0=IDLE, 1=RUN, 2=FREEZE.
- bubble_cnt_o  out  CNT_W  count of load-use bubble cycles.
- freeze_cnt_o  out  CNT_W  count of cache-freeze cycles.
- flush_cnt_o  out  CNT_W  count of branch flushes.

Behaviour:
- Source decode: rs1 = id_inst_i[19:15], rs2 = id_inst_i[24:20]. Use of each field by opcode (id_inst_i[6:0]):
  - 0110011 R-type: rs1 and rs2.
  - 0010011 I-ALU: rs1 only.
  - 0000011 lw: rs1 only.
  - 0100011 sw: rs1 and rs2.
  - 1100011 beq: rs1 and rs2.
  - Any other opcode: no sources.
- hazard = ex_memread_i & (ex_rd_i != 0) & ((use_rs1 & rs1 == ex_rd_i) | (use_rs2 & rs2 == ex_rd_i)).
- Reset (asynchronous, any time, including mid-freeze): state = IDLE, all counters 0.
- FSM transitions, evaluated each edge:
  - Any state with start_i = 0 -> IDLE.
  - IDLE with start_i = 1 -> RUN.
  - RUN with mem_stall_i = 1 -> FREEZE.
  - FREEZE with mem_stall_i = 0 -> RUN.
  - Otherwise the state holds.
- Outputs are combinational (Mealy) from state and inputs, in strict priority order:
  - P0, state == IDLE or start_i = 0: freeze_o = 1, all other outputs 0.
  - P1, mem_stall_i = 1: freeze_o = 1, pc_write_o = 0, ifid_write_o = 0, idex_bubble_o = 0, ifid_flush_o = 0. hazard and branch_taken_i are ignored; they are re-evaluated once the freeze ends.
  - P2, hazard: pc_write_o = 0, ifid_write_o = 0, idex_bubble_o = 1, ifid_flush_o = 0. A taken beq in ID is not acted on this cycle; it resolves the following cycle with forwarded data.
  - P3, branch_taken_i: pc_write_o = 1, ifid_write_o = 1, ifid_flush_o = 1.
  - P4, otherwise: pc_write_o = 1, ifid_write_o = 1, all other outputs 0.
- FREEZE with mem_stall_i = 0 (release cycle) is evaluated from P2 downward in the same cycle; there is no extra dead cycle.
- Counters increment on the edge after a P1, P2 or P3 cycle respectively.
  - Each saturates at all-ones and never wraps.
  - Counters are not cleared by start_i; only rst_i clears them.
- The output is identical for a given state/input combination regardless of history; the only sequential state is the FSM and the counters.

Test Plan:
- rst_i pulsed mid-FREEZE with counters nonzero -> state_o = 0, all counters 0, freeze_o = 1 immediately; after start_i = 1, state_o = 1 next cycle.
- RUN, ex_memread_i = 1, ex_rd_i = 5, id_inst_i = 0x00728333 (add x6,x5,x7) -> idex_bubble_o = 1, pc_write_o = 0, ifid_write_o = 0; bubble_cnt_o = 1 next cycle.
- ex_rd_i = 5, memread = 1:
  - id_inst_i = 0x00510093 (addi x1,x2,5; rs2 field = 5 but unused) -> no bubble.
  - id_inst_i = 0x00512023 (sw x5,0(x2)) -> bubble.
  - ex_rd_i = 0 with id_inst_i = 0x00100093 -> no bubble.
- mem_stall_i high for 3 cycles while hazard and branch_taken_i are both asserted:
  - During the stall: freeze_o = 1, no bubble or flush, state_o = 2, freeze_cnt_o = 3.
  - Release cycle: idex_bubble_o = 1 (hazard wins over the branch).
  - Next cycle, with the hazard gone: ifid_flush_o = 1, flush_cnt_o = 1.
- RUN, branch_taken_i = 1, no hazard -> ifid_flush_o = 1, pc_write_o = 1 for exactly the asserted cycles.
- CNT_W = 4 build, hazard held for 20 RUN cycles -> bubble_cnt_o reaches 15 and stays at 15.
